// File: rtl/johnson_decoder_4.sv
// Johnson-code decoder for a 4-bit Johnson counter.
// Tracks step sequence, declares lock, counts errors.
module johnson_decoder_4 #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       jc_in,
  input  logic             jc_valid,
  input  logic             err_clr,
  output logic [2:0]       idx,
  output logic             idx_valid,
  output logic             illegal_code,
  output logic             seq_error,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_ACQUIRE  = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [1:0] state, state_n;
  logic [3:0] good, good_n;
  logic [2:0] ref_q, ref_n;
  logic [2:0] dec_idx;
  logic       dec_ok;
  logic [2:0] step;
  logic       ill_n;
  logic       seq_n;
  logic       err_ev;

  // Map the Johnson word to its ring position; flag the 8 unused codes.
  always_comb begin
    dec_ok  = 1'b1;
    dec_idx = 3'd0;
    case (jc_in)
      4'b0000: dec_idx = 3'd0;
      4'b0001: dec_idx = 3'd1;
      4'b0011: dec_idx = 3'd2;
      4'b0111: dec_idx = 3'd3;
      4'b1111: dec_idx = 3'd4;
      4'b1110: dec_idx = 3'd5;
      4'b1100: dec_idx = 3'd6;
      4'b1000: dec_idx = 3'd7;
      default: dec_ok  = 1'b0;
    endcase
  end

  // Distance moved since the reference; 3-bit wrap makes 7->0 a +1 step.
  assign step = dec_idx - ref_q;

  // Lock FSM next-state and error pulse generation.
  always_comb begin
    state_n = state;
    good_n  = good;
    ref_n   = ref_q;
    ill_n   = 1'b0;
    seq_n   = 1'b0;
    if (jc_valid) begin
      if (!dec_ok) begin
        ill_n   = 1'b1;
        state_n = S_UNLOCKED;
        good_n  = 4'd0;
        ref_n   = 3'd0;
      end else begin
        ref_n = dec_idx;
        case (state)
          S_UNLOCKED: begin
            state_n = S_ACQUIRE;
            good_n  = 4'd0;
          end
          S_ACQUIRE: begin
            if (step == 3'd1) begin
              good_n = good + 4'd1;
              if (good_n == LOCK_TGT)
                state_n = S_LOCKED;
            end else if (step != 3'd0) begin
              seq_n  = 1'b1;
              good_n = 4'd0;
            end
          end
          S_LOCKED: begin
            if (step > 3'd1) begin
              seq_n   = 1'b1;
              state_n = S_ACQUIRE;
              good_n  = 4'd0;
            end
          end
          default: begin
            state_n = S_UNLOCKED;
            good_n  = 4'd0;
          end
        endcase
      end
    end
  end

  assign err_ev = ill_n | seq_n;

  // FSM state, reference and lock-progress registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_UNLOCKED;
      good  <= 4'd0;
      ref_q <= 3'd0;
    end else begin
      state <= state_n;
      good  <= good_n;
      ref_q <= ref_n;
    end
  end

  // Registered decode outputs and one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= 3'd0;
      idx_valid    <= 1'b0;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      idx_valid    <= jc_valid & dec_ok;
      illegal_code <= ill_n;
      seq_error    <= seq_n;
      locked       <= (state_n == S_LOCKED);
      if (jc_valid && dec_ok)
        idx <= dec_idx;
    end
  end

  // Saturating error counter; a clear coinciding with an error leaves 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= err_ev ? ERR_ONE : '0;
    end else if (err_ev && err_count != '1) begin
      err_count <= err_count + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_johnson_decoder_4.sv
// Bench for johnson_decoder_4: directed vectors,
// ring-position model, per-cycle compare.
module tb_johnson_decoder_4;

  localparam int LOCK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] jc_in;
  logic       jc_valid;
  logic       err_clr;
  logic [2:0] idx;
  logic       idx_valid;
  logic       illegal_code;
  logic       seq_error;
  logic       locked;
  logic [7:0] err_count;

  johnson_decoder_4 #(.LOCK_CNT(LOCK), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .jc_in(jc_in),
    .jc_valid(jc_valid), .err_clr(err_clr),
    .idx(idx), .idx_valid(idx_valid),
    .illegal_code(illegal_code), .seq_error(seq_error),
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  // model state: position on the 8-slot ring
  int m_idx, m_iv, m_ill, m_seq, m_lock, m_err;
  int m_ref;   // -1 = no reference
  int m_good;

  logic [3:0] ring [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++)
      if (ring[i] == c) return i;
    return -1;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_iv = 0; m_ill = 0; m_seq = 0;
    m_lock = 0; m_err = 0; m_ref = -1; m_good = 0;
  endtask

  task automatic model_step(input logic [3:0] c, input bit v, input bit clr);
    int d, st;
    bit ev;
    ev = 0; m_iv = 0; m_ill = 0; m_seq = 0;
    if (v) begin
      d = lookup(c);
      if (d < 0) begin
        m_ill = 1; ev = 1; m_ref = -1; m_good = 0; m_lock = 0;
      end else begin
        m_idx = d; m_iv = 1;
        if (m_ref < 0) begin
          m_good = 0;
        end else begin
          st = (d - m_ref + 8) % 8;
          if (st == 1) begin
            if (!m_lock) begin
              m_good++;
              if (m_good == LOCK) m_lock = 1;
            end
          end else if (st != 0) begin
            m_seq = 1; ev = 1; m_lock = 0; m_good = 0;
          end
        end
        m_ref = d;
      end
    end
    if (clr) m_err = ev ? 1 : 0;
    else if (ev && m_err < 255) m_err++;
  endtask

  task automatic drive(input logic [3:0] c, input bit v, input bit clr);
    jc_in = c; jc_valid = v; err_clr = clr;
    @(posedge clk);
    model_step(c, v, clr);
    #1;
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (started && !rst) begin
      check("idx", int'(idx), m_idx);
      check("idx_valid", int'(idx_valid), m_iv);
      check("illegal_code", int'(illegal_code), m_ill);
      check("seq_error", int'(seq_error), m_seq);
      check("locked", int'(locked), m_lock);
      check("err_count", int'(err_count), m_err);
      check("ill_seq_excl", int'(illegal_code & seq_error), 0);
    end
  end

  initial begin
    rst = 1; jc_in = 0; jc_valid = 0; err_clr = 0;
    model_reset();
    #12;
    check("rst_idx", int'(idx), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err_count), 0);
    @(negedge clk); #2 rst = 0;
    started = 1;

    // clean acquisition
    drive(4'b0000, 1, 0);
    check("clean0_idx", int'(idx), 0);
    check("clean0_lock", int'(locked), 0);
    drive(4'b0001, 1, 0);
    drive(4'b0011, 1, 0);
    drive(4'b0111, 1, 0);
    check("clean3_lock", int'(locked), 0);
    drive(4'b1111, 1, 0);
    check("clean4_idx", int'(idx), 4);
    check("clean4_lock", int'(locked), 1);

    // run to 7 then wrap to 0
    drive(4'b1110, 1, 0);
    drive(4'b1100, 1, 0);
    drive(4'b1000, 1, 0);
    drive(4'b0000, 1, 0);
    check("wrap_idx", int'(idx), 0);
    check("wrap_lock", int'(locked), 1);
    check("wrap_seq", int'(seq_error), 0);

    // jump 2 -> 5 while locked
    drive(4'b0001, 1, 0);
    drive(4'b0011, 1, 0);
    drive(4'b1110, 1, 0);
    check("jump_seq", int'(seq_error), 1);
    check("jump_lock", int'(locked), 0);
    check("jump_err", int'(err_count), 1);
    drive(4'b1100, 1, 0);
    drive(4'b1000, 1, 0);
    drive(4'b0000, 1, 0);
    check("relock3", int'(locked), 0);
    drive(4'b0001, 1, 0);
    check("relock4", int'(locked), 1);

    // hold and idle cycles
    drive(4'b0001, 1, 0);
    check("hold_lock", int'(locked), 1);
    drive(4'b0101, 0, 0);
    check("idle_iv", int'(idx_valid), 0);
    drive(4'b1010, 0, 0);

    // illegal code
    drive(4'b0101, 1, 0);
    check("ill_pulse", int'(illegal_code), 1);
    check("ill_iv", int'(idx_valid), 0);
    check("ill_idx", int'(idx), 1);
    check("ill_lock", int'(locked), 0);
    check("ill_err", int'(err_count), 2);
    drive(4'b0001, 1, 0);
    check("post_ill_seq", int'(seq_error), 0);
    check("post_ill_iv", int'(idx_valid), 1);

    // saturate the error counter
    for (int i = 0; i < 260; i++)
      drive((i % 2) ? 4'b0101 : 4'b1011, 1, 0);
    check("sat_err", int'(err_count), 255);
    drive(4'b0110, 1, 0);
    check("sat_hold", int'(err_count), 255);
    drive(4'b0110, 1, 1);
    check("clr_ev", int'(err_count), 1);
    drive(4'b0000, 0, 1);
    check("clr_only", int'(err_count), 0);

    // relock then async reset between edges
    drive(4'b0000, 1, 0);
    drive(4'b0001, 1, 0);
    drive(4'b0011, 1, 0);
    drive(4'b0111, 1, 0);
    drive(4'b1111, 1, 0);
    check("pre_rst_lock", int'(locked), 1);
    #2 rst = 1;
    #1;
    model_reset();
    check("arst_idx", int'(idx), 0);
    check("arst_iv", int'(idx_valid), 0);
    check("arst_lock", int'(locked), 0);
    check("arst_err", int'(err_count), 0);
    @(posedge clk); #2 rst = 0;

    drive(4'b0011, 1, 0);
    check("post_rst_seq", int'(seq_error), 0);
    check("post_rst_idx", int'(idx), 2);
    drive(4'b0111, 1, 0);
    drive(4'b1111, 1, 0);
    drive(4'b1110, 1, 0);
    check("post_rst_l3", int'(locked), 0);
    drive(4'b1100, 1, 0);
    check("post_rst_l4", int'(locked), 1);
    drive(4'b1100, 0, 0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/johnson_decoder_4.md
JOHNSON_DECODER_4 -- requirements
Module: johnson_decoder_4

Interface
REQ-001 Parameter: LOCK_CNT, 4, consecutive +1 steps needed to declare lock (legal range 1..15).
REQ-002 Parameter: ERR_W, 8, width of the error counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-004 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: jc_in  input  4  Johnson-code word from a 4-bit Johnson counter.
REQ-007 Port: jc_valid  input  1  jc_in is sampled on this edge.
REQ-008 Port: err_clr  input  1  synchronous clear of err_count.
REQ-009 Port: idx  output  3  decoded position 0..7 of the last legal sample.
REQ-010 Port: idx_valid  output  1  one-cycle pulse: idx updated from a legal sample.
REQ-011 Port: illegal_code  output  1  one-cycle pulse: sampled word is not a Johnson code.
REQ-012 Port: seq_error  output  1  one-cycle pulse: legal word, but not a hold or +1 step.
REQ-013 Port: locked  output  1  high while the FSM is in LOCKED.
REQ-014 Port: err_count  output  ERR_W  saturating count of illegal_code plus seq_error events.

Function
REQ-015 The decode map SHALL be 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7; the other 8 codes are illegal.
REQ-016 All outputs SHALL be registered, with 1-cycle latency from the jc_valid sampling edge to the pulse or update.
REQ-017 jc_valid=0: no pulses, idx/state/counters hold.
REQ-018 Illegal sample: illegal_code=1, idx_valid=0, idx holds, FSM->UNLOCKED, reference cleared.
REQ-019 Legal sample: idx<=decoded value, idx_valid=1; the decoded value becomes the new reference.
REQ-020 step=(new-ref) mod 8 (3-bit wrap); 7->0 is step 1.
REQ-021 FSM states: UNLOCKED (no reference), ACQUIRE (reference, good_cnt counting), LOCKED.
REQ-022 UNLOCKED + legal sample -> ACQUIRE with good_cnt=0; seq_error is never raised in UNLOCKED.
REQ-023 ACQUIRE: step 1 -> good_cnt+1, and if the result equals LOCK_CNT -> LOCKED; step 0 -> no change; other step -> seq_error=1, good_cnt=0, stay ACQUIRE.
REQ-024 LOCKED: step 0 or step 1 -> stay LOCKED; other step -> seq_error=1, ACQUIRE, good_cnt=0.
REQ-025 illegal_code and seq_error SHALL never assert in the same cycle.
REQ-026 err_count SHALL increment by 1 per error pulse and saturate at all-ones (no wrap).
REQ-027 err_clr alone SHALL give err_count=0; err_clr with an error event in the same cycle SHALL give err_count=1.
REQ-028 locked SHALL drop in the same cycle that seq_error or illegal_code asserts.

Reset
REQ-029 While rst=1, regardless of clk: idx=0, idx_valid=0, illegal_code=0, seq_error=0, locked=0, err_count=0, FSM=UNLOCKED, good_cnt=0, reference cleared.
REQ-030 rst asserted mid-sequence SHALL discard lock and reference immediately; after release, the first legal sample re-enters ACQUIRE.

Verification
REQ-031 Bench SHALL drive the clean sequence 0000,0001,0011,0111,1111 with jc_valid=1 -> idx 0,1,2,3,4 each 1 cycle later, and locked=1 on the 1111 result (LOCK_CNT=4).
REQ-032 Bench SHALL, when locked at idx=7, drive 0000 -> idx=0, locked stays 1, seq_error=0 (wrap).
REQ-033 Bench SHALL, when locked at idx=2, drive 1110 (idx 5) -> seq_error=1, locked=0, err_count+1, and then need 4 further +1 steps to relock.
REQ-034 Bench SHALL drive 0101 -> illegal_code=1, idx_valid=0, idx unchanged, locked=0, err_count+1; the next 0001 SHALL not raise seq_error.
REQ-035 Bench SHALL force err_count to 0xFF via 255+ errors, then inject an error -> stays 0xFF; err_clr with a simultaneous error -> 1.
REQ-036 Bench SHALL assert rst asynchronously between edges while locked -> all outputs 0 without waiting for clk.
